gmii_tx_fcs_regen: RTL and testbench

- Sits directly downstream of the PTP transparent-clock update stage.
- Takes its 8-bit byte stream, which is the frame without preamble and whose FCS is now stale because correctionField was rewritten.
- Emits a GMII transmit frame:
  - 7×0x55 preamble and 0xD5 SFD,
  - the frame body,
  - a freshly computed Ethernet FCS in place of the last 4 input bytes,
  - enforced inter-frame gap.

---
 rtl/gmii_tx_fcs_regen_pkg.sv | 29 ++
 rtl/gmii_tx_fcs_regen_if.sv | 33 +++
 rtl/gmii_tx_fcs_regen_crc.sv | 30 +++
 rtl/gmii_tx_fcs_regen.sv | 215 +++++++++++++++++++++
 tb/tb_gmii_tx_fcs_regen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/gmii_tx_fcs_regen_pkg.sv
// rtl/gmii_tx_fcs_regen_pkg.sv - shared constants and FSM encoding for the GMII TX FCS regenerator
//
// Purpose : byte constants, CRC-32 parameters, pipeline geometry and the
//           transmit FSM state type shared by the TX path and the RX checker.
// Ports   : none (package).

package gmii_tx_fcs_regen_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Seven preamble bytes precede the SFD; the input byte stream is delayed
    // by DELAY_DEPTH stages so the body lines up right after the SFD.
    localparam int PREAMBLE_LEN = 7;
    localparam int DELAY_DEPTH  = 8;
    localparam int FCS_LEN      = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_FCS      = 3'd3,
        ST_IFG      = 3'd4,
        ST_ABORT    = 3'd5
    } tx_state_e;

endpackage

// File: rtl/gmii_tx_fcs_regen_if.sv
// rtl/gmii_tx_fcs_regen_if.sv - byte-stream input and GMII transmit bundle
//
// Purpose : groups the upstream byte stream and the GMII TX pins.
// Signals : iv_pkt_data/i_pkt_data_wr  - frame bytes and byte strobe
//           ov_gmii_txd/o_gmii_tx_en/o_gmii_tx_er - GMII transmit pins
// Modports: master - environment side (drives bytes, observes GMII)
//           slave  - regenerator side (consumes bytes, drives GMII)

interface gmii_tx_fcs_regen_if;

    logic [7:0] iv_pkt_data;
    logic       i_pkt_data_wr;
    logic [7:0] ov_gmii_txd;
    logic       o_gmii_tx_en;
    logic       o_gmii_tx_er;

    modport master (
        output iv_pkt_data,
        output i_pkt_data_wr,
        input  ov_gmii_txd,
        input  o_gmii_tx_en,
        input  o_gmii_tx_er
    );

    modport slave (
        input  iv_pkt_data,
        input  i_pkt_data_wr,
        output ov_gmii_txd,
        output o_gmii_tx_en,
        output o_gmii_tx_er
    );

endinterface

// File: rtl/gmii_tx_fcs_regen_crc.sv
// rtl/gmii_tx_fcs_regen_crc.sv - combinational reflected CRC-32 update by one byte
//
// Purpose : next CRC register value after absorbing one byte, LSB first.
// Ports   : crc_i  [31:0] current CRC register
//           data_i [7:0]  byte to absorb
//           crc_o  [31:0] updated CRC register (not complemented)

module crc32_d8_update
    import gmii_tx_fcs_regen_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0] ^ data_i[i]) begin
                crc_v = (crc_v >> 1) ^ CRC32_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/gmii_tx_fcs_regen.sv
// rtl/gmii_tx_fcs_regen.sv - GMII transmit framer that replaces a stale FCS with a fresh one
//
// Purpose : takes a preamble-less frame byte stream whose trailing 4-byte FCS
//           is stale, emits preamble + SFD + body + recomputed FCS on GMII and
//           enforces the inter-frame gap. Runts are aborted with TX_ER, frames
//           that start too soon are dropped.
// Ports   : i_clk, i_rst_n       - 125 MHz clock, async active-low reset
//           bus (slave)          - byte stream in, GMII TXD/TX_EN/TX_ER out
//           o_frame_drop         - one-cycle pulse when an input frame is discarded
//           ov_tx_frame_cnt[15:0]- frames sent with good FCS (wraps)
//           ov_err_cnt[15:0]     - dropped plus aborted frames (wraps)

module gmii_tx_fcs_regen
    import gmii_tx_fcs_regen_pkg::*;
#(
    parameter int IFG_CYCLES = 12
)
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    gmii_tx_fcs_regen_if.slave  bus,
    output logic                o_frame_drop,
    output logic [15:0]         ov_tx_frame_cnt,
    output logic [15:0]         ov_err_cnt
);

    // An input gap of IFG_CYCLES + 8 lands the next preamble exactly
    // IFG_CYCLES after the previous TX_EN fall, given the fixed pipeline.
    localparam logic [15:0] GAP_MIN  = 16'(IFG_CYCLES + 8);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
    localparam logic [15:0] RUNT_LIM = 16'(FCS_LEN + 1);
    localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);

    tx_state_e              state_q;
    logic [15:0]            cnt_q;
    logic [7:0]             dly_data_q [DELAY_DEPTH];
    logic [DELAY_DEPTH-1:0] dly_vld_q;
    logic                   prev_wr_q;
    logic                   cap_q;
    logic [15:0]            gap_cnt_q;
    logic [31:0]            crc_q;
    logic [7:0]             txd_q;
    logic                   tx_en_q;
    logic                   tx_er_q;
    logic                   drop_q;
    logic [15:0]            frame_cnt_q;
    logic [15:0]            err_cnt_q;

    logic        wr;
    logic        pkt_rise;
    logic        gap_ok;
    logic        accept;
    logic        frame_end;
    logic        runt;
    logic [31:0] crc_next;
    logic [31:0] fcs_word;

    assign wr        = bus.i_pkt_data_wr;
    assign pkt_rise  = wr & ~prev_wr_q;
    assign gap_ok    = (gap_cnt_q >= GAP_MIN);
    assign accept    = pkt_rise & gap_ok & (state_q == ST_IDLE);
    assign frame_end = cap_q & ~wr;
    // cnt_q equals the number of bytes captured so far while in PREAMBLE.
    assign runt      = frame_end & (state_q == ST_PREAMBLE) & (cnt_q < RUNT_LIM);
    assign fcs_word  = ~crc_q;

    crc32_d8_update u_crc (
        .crc_i  (crc_q),
        .data_i (dly_data_q[DELAY_DEPTH-1]),
        .crc_o  (crc_next)
    );

    // Byte delay line with per-stage valid bits. When the frame ends, the
    // four youngest captured bytes are the stale FCS: their valid bits are
    // cleared so DATA stops right after the last body byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DELAY_DEPTH; i++) begin
                dly_data_q[i] <= 8'h00;
            end
            dly_vld_q <= '0;
            prev_wr_q <= 1'b1;   // a strobe already high at reset release is not a rise
            cap_q     <= 1'b0;
            gap_cnt_q <= GAP_MIN;
        end else begin
            prev_wr_q     <= wr;
            dly_data_q[0] <= bus.iv_pkt_data;
            for (int i = 1; i < DELAY_DEPTH; i++) begin
                dly_data_q[i] <= dly_data_q[i-1];
            end

            if (runt) begin
                dly_vld_q <= '0;
            end else if (frame_end) begin
                dly_vld_q <= {dly_vld_q[DELAY_DEPTH-2:FCS_LEN], {(FCS_LEN+1){1'b0}}};
            end else begin
                dly_vld_q <= {dly_vld_q[DELAY_DEPTH-2:0], wr & (accept | cap_q)};
            end

            if (accept) begin
                cap_q <= 1'b1;
            end else if (!wr) begin
                cap_q <= 1'b0;
            end

            if (wr) begin
                gap_cnt_q <= 16'h0000;
            end else if (gap_cnt_q < GAP_MIN) begin
                gap_cnt_q <= gap_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'h0000;
            crc_q       <= 32'h0000_0000;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            drop_q  <= pkt_rise & ~accept;

            if ((pkt_rise & ~accept) | runt) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_PREAMBLE;
                        cnt_q   <= 16'd1;
                        crc_q   <= CRC32_INIT;
                        txd_q   <= PREAMBLE_BYTE;
                        tx_en_q <= 1'b1;
                    end
                end

                ST_PREAMBLE: begin
                    tx_en_q <= 1'b1;
                    if (runt) begin
                        state_q <= ST_ABORT;
                        tx_er_q <= 1'b1;
                    end else if (cnt_q < PRE_LAST) begin
                        cnt_q <= cnt_q + 16'd1;
                        txd_q <= PREAMBLE_BYTE;
                    end else begin
                        state_q <= ST_DATA;
                        txd_q   <= SFD_BYTE;
                    end
                end

                ST_DATA: begin
                    tx_en_q <= 1'b1;
                    if (dly_vld_q[DELAY_DEPTH-1]) begin
                        txd_q <= dly_data_q[DELAY_DEPTH-1];
                        crc_q <= crc_next;
                    end else begin
                        // First FCS byte goes out on the cycle the body runs dry.
                        state_q <= ST_FCS;
                        cnt_q   <= 16'd1;
                        txd_q   <= fcs_word[7:0];
                    end
                end

                ST_FCS: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                    if (cnt_q == FCS_LAST) begin
                        state_q     <= ST_IFG;
                        cnt_q       <= 16'h0000;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 16'h0000;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_ABORT: begin
                    state_q <= ST_IFG;
                    cnt_q   <= 16'h0000;
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.ov_gmii_txd  = txd_q;
    assign bus.o_gmii_tx_en = tx_en_q;
    assign bus.o_gmii_tx_er = tx_er_q;
    assign o_frame_drop     = drop_q;
    assign ov_tx_frame_cnt  = frame_cnt_q;
    assign ov_err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_gmii_tx_fcs_regen.sv
// tb/tb_gmii_tx_fcs_regen.sv - directed self-checking bench for gmii_tx_fcs_regen

module tb_gmii_tx_fcs_regen;

    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drop;
    logic [15:0] tx_cnt;
    logic [15:0] err_cnt;

    gmii_tx_fcs_regen_if bus ();

    gmii_tx_fcs_regen #(.IFG_CYCLES(12)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .bus             (bus),
        .o_frame_drop    (drop),
        .ov_tx_frame_cnt (tx_cnt),
        .ov_err_cnt      (err_cnt)
    );

    always #4 clk = ~clk;

    int ecount = 0;
    int drop_seen = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] log_txd [0:LOGN-1];
    logic       log_en  [0:LOGN-1];
    logic       log_er  [0:LOGN-1];
    logic [7:0] fb      [0:255];

    always @(posedge clk) ecount <= ecount + 1;

    // Value registered at edge p is logged as output cycle p+1.
    always @(negedge clk) begin
        if (ecount + 1 < LOGN) begin
            log_txd[ecount+1] <= bus.ov_gmii_txd;
            log_en[ecount+1]  <= bus.o_gmii_tx_en;
            log_er[ecount+1]  <= bus.o_gmii_tx_er;
        end
        if (drop === 1'b1) drop_seen <= drop_seen + 1;
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_data   = 8'h00;
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic send(input int n, output int t0);
        t0 = ecount + 1;
        for (int i = 0; i < n; i++) begin
            bus.i_pkt_data_wr = 1'b1;
            bus.iv_pkt_data   = fb[i];
            step();
        end
        bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_data   = 8'h00;
    endtask

    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fb[k][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Whole-frame expectation: {tx_en, tx_er, txd} for output cycles T0..T0+N+9.
    task automatic check_tx(input string tag, input int t0, input int n);
        logic [31:0] fcs;
        logic [9:0]  exp_v;
        fcs = ref_fcs(n - 4);
        for (int j = 0; j <= n + 9; j++) begin
            if (j == 0 || j == n + 9) exp_v = 10'h000;
            else if (j <= 7)          exp_v = {2'b10, 8'h55};
            else if (j == 8)          exp_v = {2'b10, 8'hD5};
            else if (j <= n + 4)      exp_v = {2'b10, fb[j-9]};
            else                      exp_v = {2'b10, fcs[8*(j-n-5) +: 8]};
            chk(tag, j, {22'h0, log_en[t0+j], log_er[t0+j], log_txd[t0+j]}, {22'h0, exp_v});
        end
    endtask

    function automatic int count_en(input int a, input int b);
        int c;
        c = 0;
        for (int i = a; i <= b; i++) if (log_en[i] === 1'b1) c++;
        return c;
    endfunction

    int ta, tb, t0, t1, tr;
    logic [7:0] gold [0:12];

    initial begin
        bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_data   = 8'h00;
        gold = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        // Reset state
        idle(3);
        chk("rst_txd", 0, {24'h0, bus.ov_gmii_txd}, 32'h0);
        chk("rst_en_er_drop", 0, {29'h0, bus.o_gmii_tx_en, bus.o_gmii_tx_er, drop}, 32'h0);
        chk("rst_cnts", 0, {tx_cnt, err_cnt}, 32'h0);
        rst_n = 1'b1;
        idle(25);

        // Golden FCS: "123456789" + 4 junk bytes
        for (int i = 0; i < 13; i++) fb[i] = gold[i];
        send(13, t0);
        idle(30);
        check_tx("gold", t0, 13);
        chk("gold_fcs0", 0, {24'h0, log_txd[t0+18]}, 32'h26);
        chk("gold_fcs1", 0, {24'h0, log_txd[t0+19]}, 32'h39);
        chk("gold_fcs2", 0, {24'h0, log_txd[t0+20]}, 32'hF4);
        chk("gold_fcs3", 0, {24'h0, log_txd[t0+21]}, 32'hCB);
        chk("gold_en_len", 0, count_en(t0 - 2, t0 + 35), 21);
        chk("gold_frame_cnt", 0, {16'h0, tx_cnt}, 32'd1);

        // 64-byte frame with a wrong FCS
        for (int i = 0; i < 256; i++) fb[i] = 8'((i * 37 + 5) & 255);
        send(64, t0);
        idle(30);
        check_tx("f64", t0, 64);
        chk("f64_en_last", 72, {31'h0, log_en[t0+72]}, 32'd1);
        chk("f64_en_fall", 73, {31'h0, log_en[t0+73]}, 32'd0);
        chk("f64_frame_cnt", 0, {16'h0, tx_cnt}, 32'd2);

        // Back-to-back at the minimum gap of 20
        send(20, ta);
        idle(20);
        send(25, tb);
        idle(30);
        check_tx("b2b_a", ta, 20);
        check_tx("b2b_b", tb, 25);
        chk("b2b_ifg", 0, (tb - (ta + 29) + 1) - count_en(ta + 29, tb), 12);
        chk("b2b_drops", 0, drop_seen, 0);
        chk("b2b_frame_cnt", 0, {16'h0, tx_cnt}, 32'd4);

        // Gap of 19: second frame dropped
        send(20, ta);
        idle(19);
        send(25, tb);
        idle(40);
        check_tx("short_a", ta, 20);
        chk("short_absent", 0, count_en(ta + 29, tb + 40), 0);
        chk("short_drops", 0, drop_seen, 1);
        chk("short_err_cnt", 0, {16'h0, err_cnt}, 32'd1);
        chk("short_frame_cnt", 0, {16'h0, tx_cnt}, 32'd5);

        // Runt N=3
        send(3, t0);
        idle(30);
        for (int j = 1; j <= 3; j++)
            chk("runt_pre", j, {log_en[t0+j], log_er[t0+j], log_txd[t0+j]}, {2'b10, 8'h55});
        chk("runt_abort", 4, {log_en[t0+4], log_er[t0+4], log_txd[t0+4]}, 10'h300);
        chk("runt_after", 0, count_en(t0 + 5, t0 + 25), 0);
        chk("runt_err_cnt", 0, {16'h0, err_cnt}, 32'd2);
        chk("runt_frame_cnt", 0, {16'h0, tx_cnt}, 32'd5);

        // Reset during DATA of a 100-byte frame at T0+30
        t0 = ecount + 1;
        for (int i = 0; i < 30; i++) begin
            bus.i_pkt_data_wr = 1'b1;
            bus.iv_pkt_data   = fb[i];
            step();
        end
        rst_n = 1'b0;
        bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_data   = 8'h00;
        #1;
        chk("mid_rst_out", 0, {21'h0, bus.o_gmii_tx_en, bus.o_gmii_tx_er, bus.ov_gmii_txd, drop}, 32'h0);
        chk("mid_rst_cnts", 0, {tx_cnt, err_cnt}, 32'h0);
        tr = ecount + 1;
        idle(3);
        rst_n = 1'b1;
        idle(25);
        send(16, t1);
        idle(30);
        chk("mid_rst_no_tail", 0, count_en(tr, t1), 0);
        check_tx("post_rst", t1, 16);
        chk("post_rst_cnts", 0, {tx_cnt, err_cnt}, {16'd1, 16'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
